iobuf_packer: RTL and testbench
===============================

IOBUF_PACKER -- requirements
Module: iobuf_packer

Interface
REQ-001 Parameter: DW, 64, width of one complex sample (32-bit real, 32-bit imag).
REQ-002 Parameter: ROWS, 8, rows per frame; power of two, 2..256.
REQ-003 Port: CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port: RST  input  1  reset, synchronous, active-high.
REQ-005 Port: IN_VALID  input  1  IN_DATA holds a valid sample.
REQ-006 Port: IN_READY  output  1  packer accepts a sample this cycle.
REQ-007 Port: IN_DATA  input  DW  serial input sample.
REQ-008 Port: ROW_VALID  output  1  D0_IOBUF..D7_IOBUF hold a complete row.
REQ-009 Port: ROW_READY  input  1  downstream interface consumes the row this cycle.
REQ-010 Port: D0_IOBUF..D7_IOBUF  output  DW each  row lanes 0..7 toward the lane-rotation interface.
REQ-011 Port: SEL_PERMR  output  3  rotation select accompanying the presented row.
REQ-012 Port: ROW_LAST  output  1  presented row is row ROWS-1 of the frame.
REQ-013 Port: FRAME_DONE  output  1  one-cycle pulse when the ROW_LAST row is consumed.

Function
REQ-014 Sample accepted iff IN_VALID && IN_READY at a rising CLK edge.
REQ-015 Lane counter (3 bits) selects the fill-buffer lane for each accepted sample; increments per accept; wraps 7->0.
REQ-016 Row counter (log2(ROWS) bits) increments when a completed row transfers to the output register; wraps ROWS-1 -> 0.
REQ-017 Structure: one fill buffer (8 x DW) plus one output register (8 x DW + SEL_PERMR + ROW_LAST).
REQ-018 On the edge accepting lane 7: if the output register is empty, or ROW_VALID && ROW_READY in that cycle, the completed row (lane 7 from IN_DATA) loads into the output register and ROW_VALID = 1 next cycle.
REQ-019 Otherwise the row is held in the fill buffer, PEND = 1, and IN_READY = 0 until the transfer.
REQ-020 While PEND = 1, the first ROW_VALID && ROW_READY edge transfers the held row (ROW_VALID stays 1) and clears PEND; IN_READY = 1 in the next cycle.
REQ-021 IN_READY = !PEND && !RST (combinational).
REQ-022 ROW_VALID && ROW_READY with no row transferring: ROW_VALID = 0 next cycle.
REQ-023 Output register, SEL_PERMR and ROW_LAST stay stable while ROW_VALID && !ROW_READY.
REQ-024 Latency: first lane accepted at cycle t with IN_VALID held high => ROW_VALID at t+8.
REQ-025 With IN_VALID and ROW_READY held high: sustained throughput 1 sample/cycle, IN_READY never drops.
REQ-026 ROW_LAST = 1 iff the loaded row had row counter = ROWS-1.
REQ-027 FRAME_DONE = 1 for exactly the cycle after ROW_VALID && ROW_READY && ROW_LAST.
REQ-028 IN_VALID and IN_DATA are ignored when IN_READY = 0; no partial-row flush exists.

Reset
REQ-029 RST high at an edge: lane counter, row counter, PEND, ROW_VALID, ROW_LAST, FRAME_DONE, SEL_PERMR, D0_IOBUF..D7_IOBUF = 0.
REQ-030 Reset mid-row or mid-frame discards the partial row and any pending row; the next accepted sample is lane 0 of row 0.
REQ-031 The fill buffer contents are not reset; they are unobservable until overwritten.

Configuration
REQ-032 Macro IOBUF_PACKER_SKEW_EN defined: SEL_PERMR loads the row counter modulo 8 with each row (diagonal skew for the downstream rotator).
REQ-033 Macro IOBUF_PACKER_SKEW_EN undefined: SEL_PERMR is constant 0 (identity rotation); all other behaviour is identical.

Verification
REQ-034 Reset, IN_VALID=1, IN_DATA = 0..15, ROW_READY=1 -> ROW_VALID at cycle 8 with D0..D7 = 0..7, and at cycle 16 with 8..15; IN_READY is 1 throughout.
REQ-035 With SKEW_EN, ROWS=8, 64 samples, ROW_READY=1 -> SEL_PERMR = 0,1,...,7 on successive rows; ROW_LAST on row 7 only; single FRAME_DONE pulse; without SKEW_EN, SEL_PERMR = 0 always.
REQ-036 ROW_READY=0, stream 16 samples -> row 0 presented and stable; IN_READY drops the cycle after sample 15 is accepted; ROW_READY pulse for 1 cycle -> row 1 presented next cycle, IN_READY=1 the cycle after.
REQ-037 RST asserted after 5 samples of row 2 -> all outputs 0; the next 8 samples form row 0 with SEL_PERMR=0.
REQ-038 Random IN_VALID/ROW_READY, 10 frames of ROWS=8 -> scoreboard shows every sample in order, in the correct lane and row; no loss or duplication; FRAME_DONE count = 10.

Source files
------------

// File: rtl/iobuf_packer.sv
// rtl/iobuf_packer.sv - serial-to-row packer feeding 8 lanes; IOBUF_PACKER_SKEW_EN enables diagonal SEL_PERMR
module iobuf_packer #(
  parameter int DW   = 64,
  parameter int ROWS = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [DW-1:0] IN_DATA,
  output logic          ROW_VALID,
  input  logic          ROW_READY,
  output logic [DW-1:0] D0_IOBUF,
  output logic [DW-1:0] D1_IOBUF,
  output logic [DW-1:0] D2_IOBUF,
  output logic [DW-1:0] D3_IOBUF,
  output logic [DW-1:0] D4_IOBUF,
  output logic [DW-1:0] D5_IOBUF,
  output logic [DW-1:0] D6_IOBUF,
  output logic [DW-1:0] D7_IOBUF,
  output logic [2:0]    SEL_PERMR,
  output logic          ROW_LAST,
  output logic          FRAME_DONE
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

  logic [2:0]    lane_cnt;
  logic [RW-1:0] row_cnt;
  logic          pend;
  logic [DW-1:0] fill [8];
  logic [DW-1:0] outq [8];

  logic accept, consume, complete, load_new, load_pend, transfer;

  // A held (pending) row blocks input until it moves to the output register.
  assign IN_READY  = !pend && !RST;
  assign accept    = IN_VALID && IN_READY;
  assign consume   = ROW_VALID && ROW_READY;
  assign complete  = accept && (lane_cnt == 3'd7);
  assign load_new  = complete && (!ROW_VALID || consume);
  assign load_pend = pend && consume;
  assign transfer  = load_new || load_pend;

  assign D0_IOBUF = outq[0];
  assign D1_IOBUF = outq[1];
  assign D2_IOBUF = outq[2];
  assign D3_IOBUF = outq[3];
  assign D4_IOBUF = outq[4];
  assign D5_IOBUF = outq[5];
  assign D6_IOBUF = outq[6];
  assign D7_IOBUF = outq[7];

  // Fill buffer: written lane by lane, deliberately left unreset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      fill[lane_cnt] <= IN_DATA;
    end
  end

  // Output row register: lane 7 bypasses the fill buffer on a direct load.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 8; i++) outq[i] <= '0;
    end else if (load_new) begin
      for (int i = 0; i < 7; i++) outq[i] <= fill[i];
      outq[7] <= IN_DATA;
    end else if (load_pend) begin
      for (int i = 0; i < 8; i++) outq[i] <= fill[i];
    end
  end

  // Lane/row counters, pending flag and row handshake state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lane_cnt   <= 3'd0;
      row_cnt    <= '0;
      pend       <= 1'b0;
      ROW_VALID  <= 1'b0;
      ROW_LAST   <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      if (accept) begin
        lane_cnt <= lane_cnt + 3'd1;
      end
      if (complete && !load_new) begin
        pend <= 1'b1;
      end else if (load_pend) begin
        pend <= 1'b0;
      end
      if (transfer) begin
        row_cnt   <= (row_cnt == ROW_MAX) ? '0 : row_cnt + 1'b1;
        ROW_LAST  <= (row_cnt == ROW_MAX);
        ROW_VALID <= 1'b1;
      end else if (consume) begin
        ROW_VALID <= 1'b0;
      end
      FRAME_DONE <= consume && ROW_LAST;
    end
  end

`ifdef IOBUF_PACKER_SKEW_EN
  logic [2:0] row_sel;

  if (RW >= 3) begin : g_sel_wide
    assign row_sel = row_cnt[2:0];
  end else begin : g_sel_narrow
    assign row_sel = {{(3 - RW){1'b0}}, row_cnt};
  end

  // Rotation select travels with the row: row counter modulo 8.
  always_ff @(posedge CLK) begin
    if (RST) begin
      SEL_PERMR <= 3'd0;
    end else if (transfer) begin
      SEL_PERMR <= row_sel;
    end
  end
`else
  assign SEL_PERMR = 3'd0;
`endif

endmodule

// File: tb/tb_iobuf_packer.sv
// tb/tb_iobuf_packer.sv - table vectors plus directed and random scoreboard sequences for iobuf_packer
module tb_iobuf_packer;

`ifdef IOBUF_PACKER_SKEW_EN
  localparam bit SKEW = 1'b1;
`else
  localparam bit SKEW = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [63:0] IN_DATA = '0;
  logic        ROW_VALID;
  logic        ROW_READY = 1'b0;
  logic [63:0] dl [8];
  logic [2:0]  SEL_PERMR;
  logic        ROW_LAST;
  logic        FRAME_DONE;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  iobuf_packer #(.DW(64), .ROWS(8)) dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .ROW_VALID(ROW_VALID), .ROW_READY(ROW_READY),
    .D0_IOBUF(dl[0]), .D1_IOBUF(dl[1]), .D2_IOBUF(dl[2]), .D3_IOBUF(dl[3]),
    .D4_IOBUF(dl[4]), .D5_IOBUF(dl[5]), .D6_IOBUF(dl[6]), .D7_IOBUF(dl[7]),
    .SEL_PERMR(SEL_PERMR), .ROW_LAST(ROW_LAST), .FRAME_DONE(FRAME_DONE)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [63:0] dat;
    logic        rr;
    logic        e_ir;
    logic        e_rv;
    logic        chk_d;
    logic [63:0] e_d0;
    logic [63:0] e_d7;
    int          e_row;
    logic        e_last;
    logic        e_fd;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(logic rst, logic iv, logic [63:0] dat, logic rr,
                              logic e_ir, logic e_rv, logic chk_d,
                              logic [63:0] e_d0, logic [63:0] e_d7,
                              int e_row, logic e_last, logic e_fd);
    vec_t v;
    v.rst = rst; v.iv = iv; v.dat = dat; v.rr = rr;
    v.e_ir = e_ir; v.e_rv = e_rv; v.chk_d = chk_d;
    v.e_d0 = e_d0; v.e_d7 = e_d7; v.e_row = e_row;
    v.e_last = e_last; v.e_fd = e_fd;
    return v;
  endfunction

  function automatic logic [2:0] exp_sel(int row);
    return SKEW ? 3'(row % 8) : 3'd0;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  int   sent, rows_out, fd_cnt;
  logic acc, cons, exp_fd;

  initial begin
    //               rst iv dat    rr ir rv cd d0     d7     row last fd
    vecs[0]  = mk(1, 0, 64'd0,  1, 0, 0, 1, 64'd0, 64'd0,  0, 0, 0);
    vecs[1]  = mk(0, 1, 64'd0,  1, 1, 0, 0, 64'd0, 64'd0,  0, 0, 0);
    vecs[2]  = mk(0, 1, 64'd1,  1, 1, 0, 0, 64'd0, 64'd0,  0, 0, 0);
    vecs[3]  = mk(0, 1, 64'd2,  1, 1, 0, 0, 64'd0, 64'd0,  0, 0, 0);
    vecs[4]  = mk(0, 1, 64'd3,  1, 1, 0, 0, 64'd0, 64'd0,  0, 0, 0);
    vecs[5]  = mk(0, 1, 64'd4,  1, 1, 0, 0, 64'd0, 64'd0,  0, 0, 0);
    vecs[6]  = mk(0, 1, 64'd5,  1, 1, 0, 0, 64'd0, 64'd0,  0, 0, 0);
    vecs[7]  = mk(0, 1, 64'd6,  1, 1, 0, 0, 64'd0, 64'd0,  0, 0, 0);
    vecs[8]  = mk(0, 1, 64'd7,  1, 1, 1, 1, 64'd0, 64'd7,  0, 0, 0);
    vecs[9]  = mk(0, 1, 64'd8,  1, 1, 0, 0, 64'd0, 64'd0,  0, 0, 0);
    vecs[10] = mk(0, 1, 64'd9,  1, 1, 0, 0, 64'd0, 64'd0,  0, 0, 0);
    vecs[11] = mk(0, 1, 64'd10, 1, 1, 0, 0, 64'd0, 64'd0,  0, 0, 0);
    vecs[12] = mk(0, 1, 64'd11, 1, 1, 0, 0, 64'd0, 64'd0,  0, 0, 0);
    vecs[13] = mk(0, 1, 64'd12, 1, 1, 0, 0, 64'd0, 64'd0,  0, 0, 0);
    vecs[14] = mk(0, 1, 64'd13, 1, 1, 0, 0, 64'd0, 64'd0,  0, 0, 0);
    vecs[15] = mk(0, 1, 64'd14, 1, 1, 0, 0, 64'd0, 64'd0,  0, 0, 0);
    vecs[16] = mk(0, 1, 64'd15, 1, 1, 1, 1, 64'd8, 64'd15, 1, 0, 0);
    vecs[17] = mk(0, 0, 64'd0,  1, 1, 0, 0, 64'd0, 64'd0,  0, 0, 0);

    // Table: reset state and a 16-sample stream with downstream always ready.
    for (int k = 0; k < 18; k++) begin
      RST = vecs[k].rst; IN_VALID = vecs[k].iv;
      IN_DATA = vecs[k].dat; ROW_READY = vecs[k].rr;
      tick();
      chk($sformatf("v%0d_in_ready", k), 64'(IN_READY), 64'(vecs[k].e_ir));
      chk($sformatf("v%0d_row_valid", k), 64'(ROW_VALID), 64'(vecs[k].e_rv));
      chk($sformatf("v%0d_frame_done", k), 64'(FRAME_DONE), 64'(vecs[k].e_fd));
      if (vecs[k].chk_d) begin
        chk($sformatf("v%0d_d0", k), dl[0], vecs[k].e_d0);
        chk($sformatf("v%0d_d7", k), dl[7], vecs[k].e_d7);
        chk($sformatf("v%0d_sel", k), 64'(SEL_PERMR), 64'(exp_sel(vecs[k].e_row)));
        chk($sformatf("v%0d_last", k), 64'(ROW_LAST), 64'(vecs[k].e_last));
      end
    end

    // Backpressure: second row pends, input stalls, one-cycle ready releases it.
    RST = 1; IN_VALID = 0; ROW_READY = 0; tick(); RST = 0;
    for (int i = 0; i < 16; i++) begin
      IN_VALID = 1; IN_DATA = 64'(100 + i);
      #1;
      chk($sformatf("bp_in_ready_%0d", i), 64'(IN_READY), 64'd1);
      tick();
    end
    chk("bp_stall_ready", 64'(IN_READY), 64'd0);
    chk("bp_row0_valid", 64'(ROW_VALID), 64'd1);
    chk("bp_row0_d0", dl[0], 64'd100);
    chk("bp_row0_d7", dl[7], 64'd107);
    IN_DATA = 64'd999;
    repeat (3) tick();
    chk("bp_hold_ready", 64'(IN_READY), 64'd0);
    chk("bp_hold_d0", dl[0], 64'd100);
    chk("bp_hold_d7", dl[7], 64'd107);
    chk("bp_hold_sel", 64'(SEL_PERMR), 64'(exp_sel(0)));
    ROW_READY = 1; tick(); ROW_READY = 0; IN_VALID = 0;
    chk("bp_row1_valid", 64'(ROW_VALID), 64'd1);
    chk("bp_row1_d0", dl[0], 64'd108);
    chk("bp_row1_d7", dl[7], 64'd115);
    chk("bp_row1_sel", 64'(SEL_PERMR), 64'(exp_sel(1)));
    chk("bp_release_ready", 64'(IN_READY), 64'd1);
    chk("bp_no_frame_done", 64'(FRAME_DONE), 64'd0);

    // Reset in the middle of row 2 discards it; the restart is row 0.
    RST = 1; tick(); RST = 0; ROW_READY = 1;
    for (int i = 0; i < 21; i++) begin
      IN_VALID = 1; IN_DATA = 64'(i); tick();
    end
    RST = 1; IN_VALID = 0; tick();
    chk("rst_row_valid", 64'(ROW_VALID), 64'd0);
    chk("rst_d0", dl[0], 64'd0);
    chk("rst_d7", dl[7], 64'd0);
    chk("rst_sel", 64'(SEL_PERMR), 64'd0);
    chk("rst_last", 64'(ROW_LAST), 64'd0);
    chk("rst_in_ready", 64'(IN_READY), 64'd0);
    RST = 0;
    for (int i = 0; i < 8; i++) begin
      IN_VALID = 1; IN_DATA = 64'(200 + i); tick();
    end
    IN_VALID = 0;
    chk("rst_new_valid", 64'(ROW_VALID), 64'd1);
    chk("rst_new_d0", dl[0], 64'd200);
    chk("rst_new_d7", dl[7], 64'd207);
    chk("rst_new_sel", 64'(SEL_PERMR), 64'd0);
    chk("rst_new_last", 64'(ROW_LAST), 64'd0);

    // Random handshakes over 10 frames, checked against an in-order scoreboard.
    RST = 1; ROW_READY = 0; tick(); RST = 0;
    sent = 0; rows_out = 0; fd_cnt = 0;
    for (int cyc = 0; cyc < 20000 && rows_out < 80; cyc++) begin
      IN_VALID  = (sent < 640) && ($urandom_range(0, 3) != 0);
      IN_DATA   = 64'hA500_0000_0000_0000 | 64'(sent);
      ROW_READY = ($urandom_range(0, 2) != 0);
      #1;
      acc  = IN_VALID && IN_READY;
      cons = ROW_VALID && ROW_READY;
      if (cons) begin
        for (int l = 0; l < 8; l++)
          chk($sformatf("sb_r%0d_l%0d", rows_out, l), dl[l],
              64'hA500_0000_0000_0000 | 64'(rows_out * 8 + l));
        chk($sformatf("sb_r%0d_sel", rows_out), 64'(SEL_PERMR), 64'(exp_sel(rows_out)));
        chk($sformatf("sb_r%0d_last", rows_out), 64'(ROW_LAST), 64'((rows_out % 8) == 7));
        rows_out++;
      end
      exp_fd = cons && ROW_LAST;
      if (acc) sent++;
      tick();
      chk("sb_frame_done", 64'(FRAME_DONE), 64'(exp_fd));
      if (FRAME_DONE) fd_cnt++;
    end
    ROW_READY = 0; IN_VALID = 0;
    chk("sb_rows_out", 64'(rows_out), 64'd80);
    chk("sb_frame_count", 64'(fd_cnt), 64'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
